voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter VOICES, default 8: number of synth voices.
REQ-002 SHALL have parameter V_WIDTH, default 3: voice index width, equal to log2(VOICES).
REQ-003 SHALL use one clock, CLOCK_25; reset iRST_N is synchronous and active-low.
REQ-004 SHALL have port CLOCK_25  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port iRST_N  in  1  synchronous active-low reset.
REQ-006 SHALL have port note_req  in  1  note request strobe; accepted when note_req & req_ready & !all_off.
REQ-007 SHALL have port note_on_off  in  1  1 = note on, 0 = note off.
REQ-008 SHALL have port note_key  in  7  MIDI key number.
REQ-009 SHALL have port note_vel  in  7  MIDI velocity.
REQ-010 SHALL have port all_off  in  1  all-notes-off strobe.
REQ-011 SHALL have port voice_free  in  VOICES  per-voice envelope-release-complete flag from the synth engine.
REQ-012 SHALL have port req_ready  out  1  registered; allocator idle.
REQ-013 SHALL have port keys_on  out  VOICES  per-voice gate.
REQ-014 SHALL have port evt_valid  out  1  one-cycle voice event strobe.
REQ-015 SHALL have port evt_voice  out  V_WIDTH  event voice index.
REQ-016 SHALL have port evt_key  out  8  event key; 8'hff on off events.
REQ-017 SHALL have port evt_vel  out  8  event velocity.
REQ-018 SHALL have port evt_on  out  1  1 = gate on event, 0 = gate off event.
REQ-019 SHALL have port evt_steal  out  1  event caused by voice stealing.
REQ-020 SHALL have port active_count  out  V_WIDTH+1  registered popcount of keys_on.
REQ-021 SHALL have port off_miss  out  1  sticky: a note off matched no voice.

Function
REQ-022 SHALL implement FSM states IDLE, SCAN, STEAL_OFF, ISSUE; req_ready=1 only in IDLE.
REQ-023 SHALL register the request (on_off, key, vel) on acceptance; note on with vel==0 is treated as note off.
REQ-024 SHALL hold a per-voice key register (8 bit, 8'hff = none) and an 8-bit age counter.
REQ-025 SCAN: SHALL examine exactly one voice per cycle, index 0..VOICES-1, taking VOICES cycles.
REQ-026 Note on, candidate priority: (a) voice with keys_on=1 and the same key (retrigger); (b) lowest-index voice with keys_on=0 and voice_free=1; (c) voice with keys_on=0 and maximum age; (d) voice with keys_on=1 and maximum age (steal). Age ties SHALL go to the lowest index.
REQ-027 Steal case (d): SHALL go SCAN->STEAL_OFF, emitting an off event (evt_on=0, evt_steal=1, evt_key=8'hff), then go to ISSUE.
REQ-028 ISSUE: SHALL emit the on event (evt_on=1, evt_key={1'b0,key}, evt_vel={1'b0,vel}, evt_steal=1 only when stealing), set keys_on and the key register, and return to IDLE.
REQ-029 On allocation, the chosen voice's age SHALL be 0; every other voice's age SHALL increment, saturating at 255.
REQ-030 Note off: SHALL select the lowest-index voice with keys_on=1 and the same key, emit an off event in ISSUE (evt_vel=vel), clear keys_on, and set the key register to 8'hff.
REQ-031 Note off with no match: SHALL emit no event, set off_miss, and return to IDLE.
REQ-032 Latency: accepted at edge k; event at cycle k+VOICES+1 (steal on event at k+VOICES+2); req_ready=1 the cycle after the last event.
REQ-033 keys_on and active_count SHALL change on the same edge that asserts evt_valid; a retrigger leaves active_count unchanged.
REQ-034 all_off, sampled in any state, SHALL clear keys_on and the key registers and return to IDLE next cycle; an in-flight request is dropped, with no events and off_miss unchanged.
REQ-035 all_off coincident with note_req SHALL win; the request is not accepted.
REQ-036 voice_free SHALL be sampled through one register stage before use.

Reset
REQ-037 On iRST_N=0 at a clock edge, SHALL set: state IDLE, req_ready=1, keys_on=0, evt_valid=0, evt_voice=0, evt_key=8'hff, evt_vel=0, evt_on=0, evt_steal=0, active_count=0, off_miss=0, key registers=8'hff, ages=0.
REQ-038 Reset mid-SCAN or mid-STEAL_OFF SHALL abort the operation with no event emitted.

Verification
REQ-039 Bench SHALL cover: after reset, all voice_free=1, note on key 60 vel 100 -> evt at k+9, voice 0, keys_on=8'h01, active_count=1.
REQ-040 Bench SHALL cover: 8 note ons (keys 60-67), then key 70 -> off event voice 0 with evt_steal=1, then on event voice 0 key 70; active_count stays 8.
REQ-041 Bench SHALL cover: note off key 99 with nothing held -> no evt_valid, off_miss=1 sticky until reset.
REQ-042 Bench SHALL cover: note on key 60, then note on key 60 vel 0 -> off event voice 0, keys_on=0.
REQ-043 Bench SHALL cover: all_off asserted during SCAN of a note on -> no event, keys_on=0, req_ready=1 next cycle.
REQ-044 Bench SHALL cover: voice 2 released (keys_on=0, voice_free=0), voices 0,1,3-7 on -> next note on selects voice 2 with no steal.

Source files
------------

// File: rtl/voice_allocator.sv
`timescale 1ns/1ps
// Polyphonic voice allocator: a sequential scan, one voice per cycle, picks a voice for each note
// request. It retriggers, uses a free voice, reuses the oldest idle voice, or steals the oldest held voice.
module voice_allocator #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic               CLOCK_25,
    input  logic               iRST_N,
    input  logic               note_req,
    input  logic               note_on_off,
    input  logic [6:0]         note_key,
    input  logic [6:0]         note_vel,
    input  logic               all_off,
    input  logic [VOICES-1:0]  voice_free,
    output logic               req_ready,
    output logic [VOICES-1:0]  keys_on,
    output logic               evt_valid,
    output logic [V_WIDTH-1:0] evt_voice,
    output logic [7:0]         evt_key,
    output logic [7:0]         evt_vel,
    output logic               evt_on,
    output logic               evt_steal,
    output logic [V_WIDTH:0]   active_count,
    output logic               off_miss
);

    // state     | meaning
    // IDLE      | waiting for a request; req_ready is high one cycle after the last event
    // SCAN      | examining voice scan_idx, one voice per cycle
    // STEAL_OFF | emitting the gate-off event for a stolen voice
    // ISSUE     | emitting the final on/off event, or flagging an unmatched note off
    typedef enum logic [1:0] {IDLE, SCAN, STEAL_OFF, ISSUE} state_t;

    localparam logic [V_WIDTH-1:0] LAST = V_WIDTH'(VOICES - 1);

    state_t             state;
    logic               req_on;
    logic [6:0]         req_key, req_vel;
    logic [7:0]         key_r [VOICES];
    logic [7:0]         age_r [VOICES];
    logic [VOICES-1:0]  vf_q;
    logic [V_WIDTH-1:0] scan_idx, sel_idx;
    logic               sel_hit, steal_r;

    logic               m_found, f_found, i_found, o_found;
    logic [V_WIDTH-1:0] m_idx, f_idx, i_idx, o_idx;
    logic [7:0]         i_age, o_age;
    logic               m_found_n, f_found_n, i_found_n, o_found_n;
    logic [V_WIDTH-1:0] m_idx_n, f_idx_n, i_idx_n, o_idx_n;
    logic [7:0]         i_age_n, o_age_n;

    // Candidate trackers updated with the voice under examination; strict > keeps age ties at the lowest index.
    always_comb begin
        m_found_n = m_found; m_idx_n = m_idx;
        f_found_n = f_found; f_idx_n = f_idx;
        i_found_n = i_found; i_idx_n = i_idx; i_age_n = i_age;
        o_found_n = o_found; o_idx_n = o_idx; o_age_n = o_age;
        if (keys_on[scan_idx] && key_r[scan_idx] == {1'b0, req_key} && !m_found) begin
            m_found_n = 1'b1; m_idx_n = scan_idx;
        end
        if (!keys_on[scan_idx] && vf_q[scan_idx] && !f_found) begin
            f_found_n = 1'b1; f_idx_n = scan_idx;
        end
        if (!keys_on[scan_idx] && (!i_found || age_r[scan_idx] > i_age)) begin
            i_found_n = 1'b1; i_idx_n = scan_idx; i_age_n = age_r[scan_idx];
        end
        if (keys_on[scan_idx] && (!o_found || age_r[scan_idx] > o_age)) begin
            o_found_n = 1'b1; o_idx_n = scan_idx; o_age_n = age_r[scan_idx];
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (!iRST_N) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            keys_on      <= '0;
            evt_valid    <= 1'b0;
            evt_voice    <= '0;
            evt_key      <= 8'hff;
            evt_vel      <= 8'h00;
            evt_on       <= 1'b0;
            evt_steal    <= 1'b0;
            active_count <= '0;
            off_miss     <= 1'b0;
            req_on       <= 1'b0;
            req_key      <= '0;
            req_vel      <= '0;
            vf_q         <= '0;
            scan_idx     <= '0;
            sel_idx      <= '0;
            sel_hit      <= 1'b0;
            steal_r      <= 1'b0;
            {m_found, f_found, i_found, o_found} <= '0;
            {m_idx, f_idx, i_idx, o_idx}         <= '0;
            i_age        <= '0;
            o_age        <= '0;
            for (int v = 0; v < VOICES; v++) begin
                key_r[v] <= 8'hff;
                age_r[v] <= 8'h00;
            end
        end else begin
            vf_q      <= voice_free;
            evt_valid <= 1'b0;
            if (all_off) begin
                state        <= IDLE;
                req_ready    <= 1'b1;
                keys_on      <= '0;
                active_count <= '0;
                for (int v = 0; v < VOICES; v++) key_r[v] <= 8'hff;
            end else begin
                case (state)
                    IDLE: begin
                        if (note_req && req_ready) begin
                            state     <= SCAN;
                            req_ready <= 1'b0;
                            req_on    <= note_on_off && (note_vel != 7'd0);
                            req_key   <= note_key;
                            req_vel   <= note_vel;
                            scan_idx  <= '0;
                            {m_found, f_found, i_found, o_found} <= '0;
                        end else begin
                            req_ready <= 1'b1;
                        end
                    end
                    SCAN: begin
                        m_found <= m_found_n; m_idx <= m_idx_n;
                        f_found <= f_found_n; f_idx <= f_idx_n;
                        i_found <= i_found_n; i_idx <= i_idx_n; i_age <= i_age_n;
                        o_found <= o_found_n; o_idx <= o_idx_n; o_age <= o_age_n;
                        scan_idx <= scan_idx + 1'b1;
                        if (scan_idx == LAST) begin
                            state   <= ISSUE;
                            steal_r <= 1'b0;
                            sel_hit <= 1'b1;
                            if (!req_on) begin
                                sel_idx <= m_idx_n;
                                sel_hit <= m_found_n;
                            end else if (m_found_n) begin
                                sel_idx <= m_idx_n;
                            end else if (f_found_n) begin
                                sel_idx <= f_idx_n;
                            end else if (i_found_n) begin
                                sel_idx <= i_idx_n;
                            end else begin
                                sel_idx <= o_idx_n;
                                steal_r <= 1'b1;
                                state   <= STEAL_OFF;
                            end
                        end
                    end
                    STEAL_OFF: begin
                        evt_valid        <= 1'b1;
                        evt_voice        <= sel_idx;
                        evt_key          <= 8'hff;
                        evt_vel          <= 8'h00;
                        evt_on           <= 1'b0;
                        evt_steal        <= 1'b1;
                        keys_on[sel_idx] <= 1'b0;
                        key_r[sel_idx]   <= 8'hff;
                        active_count     <= active_count - 1'b1;
                        state            <= ISSUE;
                    end
                    ISSUE: begin
                        state <= IDLE;
                        if (req_on) begin
                            evt_valid        <= 1'b1;
                            evt_voice        <= sel_idx;
                            evt_key          <= {1'b0, req_key};
                            evt_vel          <= {1'b0, req_vel};
                            evt_on           <= 1'b1;
                            evt_steal        <= steal_r;
                            keys_on[sel_idx] <= 1'b1;
                            key_r[sel_idx]   <= {1'b0, req_key};
                            if (!keys_on[sel_idx]) active_count <= active_count + 1'b1;
                            for (int v = 0; v < VOICES; v++) begin
                                if (V_WIDTH'(v) == sel_idx) age_r[v] <= 8'h00;
                                else if (age_r[v] != 8'hff) age_r[v] <= age_r[v] + 8'd1;
                            end
                        end else if (sel_hit) begin
                            evt_valid        <= 1'b1;
                            evt_voice        <= sel_idx;
                            evt_key          <= 8'hff;
                            evt_vel          <= {1'b0, req_vel};
                            evt_on           <= 1'b0;
                            evt_steal        <= 1'b0;
                            keys_on[sel_idx] <= 1'b0;
                            key_r[sel_idx]   <= 8'hff;
                            active_count     <= active_count - 1'b1;
                        end else begin
                            off_miss <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
`timescale 1ns/1ps
// Bench for voice_allocator: a table of note requests, each with hand-derived expected events.
// The events are queued on a scoreboard, and a few sequences cover the all_off and reset aborts.
module tb_voice_allocator;

    logic       CLOCK_25 = 1'b0;
    logic       iRST_N = 1'b0;
    logic       note_req = 1'b0, note_on_off = 1'b0, all_off = 1'b0;
    logic [6:0] note_key = '0, note_vel = '0;
    logic [7:0] voice_free = 8'hff;
    logic       req_ready, evt_valid, evt_on, evt_steal, off_miss;
    logic [7:0] keys_on, evt_key, evt_vel;
    logic [2:0] evt_voice;
    logic [3:0] active_count;

    voice_allocator #(.VOICES(8), .V_WIDTH(3)) dut (
        .CLOCK_25(CLOCK_25), .iRST_N(iRST_N), .note_req(note_req), .note_on_off(note_on_off),
        .note_key(note_key), .note_vel(note_vel), .all_off(all_off), .voice_free(voice_free),
        .req_ready(req_ready), .keys_on(keys_on), .evt_valid(evt_valid), .evt_voice(evt_voice),
        .evt_key(evt_key), .evt_vel(evt_vel), .evt_on(evt_on), .evt_steal(evt_steal),
        .active_count(active_count), .off_miss(off_miss)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    typedef struct {
        logic [2:0] voice;
        logic [7:0] key;
        logic [7:0] vel;
        logic       on;
        logic       steal;
    } evt_t;

    typedef struct {
        logic [7:0] vf;
        logic       on;
        logic [6:0] key, vel;
        int         nev;
        logic [2:0] voice;
        logic [7:0] ekey, evel;
        logic       eon, esteal;
        logic [7:0] keys;
        int         cnt;
        logic       miss;
    } rec_t;

    evt_t exp_q[$];
    rec_t tbl[15];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic [7:0] vf, input logic on, input int key, input int vel,
                                input int nev, input int voice, input int ekey, input int evel,
                                input logic eon, input logic esteal, input logic [7:0] keys,
                                input int cnt, input logic miss);
        rec_t r;
        r.vf = vf; r.on = on; r.key = 7'(key); r.vel = 7'(vel); r.nev = nev;
        r.voice = 3'(voice); r.ekey = 8'(ekey); r.evel = 8'(evel); r.eon = eon;
        r.esteal = esteal; r.keys = keys; r.cnt = cnt; r.miss = miss;
        return r;
    endfunction

    always @(negedge CLOCK_25) begin
        if (iRST_N && evt_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", 1, 0);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                chk("evt_voice", int'(evt_voice), int'(e.voice));
                chk("evt_key", int'(evt_key), int'(e.key));
                chk("evt_vel", int'(evt_vel), int'(e.vel));
                chk("evt_on", int'(evt_on), int'(e.on));
                chk("evt_steal", int'(evt_steal), int'(e.steal));
            end
        end
    end

    task automatic run_rec(input rec_t r);
        int lat0 = -1, lat1 = -1, nseen = 0;
        bit done = 0;
        @(negedge CLOCK_25);
        voice_free = r.vf;
        repeat (2) @(negedge CLOCK_25);
        chk("ready_before_req", int'(req_ready), 1);
        if (r.nev == 2) exp_q.push_back('{r.voice, 8'hff, 8'h00, 1'b0, 1'b1});
        if (r.nev >= 1) exp_q.push_back('{r.voice, r.ekey, r.evel, r.eon, r.esteal});
        note_req = 1'b1; note_on_off = r.on; note_key = r.key; note_vel = r.vel;
        @(posedge CLOCK_25); #1;
        note_req = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge CLOCK_25); #1;
            if (evt_valid) begin
                if (nseen == 0) lat0 = c; else lat1 = c;
                nseen++;
            end
            if (req_ready) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("ready_timeout", 0, 1);
        chk("num_events", nseen, r.nev);
        if (r.nev >= 1) chk("first_evt_latency", lat0, 9);
        if (r.nev == 2) chk("steal_on_latency", lat1, 10);
        chk("keys_on", int'(keys_on), int'(r.keys));
        chk("active_count", int'(active_count), r.cnt);
        chk("off_miss", int'(off_miss), int'(r.miss));
    endtask

    task automatic count_quiet(input string name, input int cycles);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge CLOCK_25); #1;
            if (evt_valid) seen++;
        end
        chk(name, seen, 0);
    endtask

    task automatic start_req(input logic on, input int key, input int vel);
        @(negedge CLOCK_25);
        note_req = 1'b1; note_on_off = on; note_key = 7'(key); note_vel = 7'(vel);
        @(posedge CLOCK_25); #1;
        note_req = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(8'hff, 1, 60 + i, 100, 1, i, 60 + i, 100, 1, 0, 8'((1 << (i + 1)) - 1), i + 1, 0);
        tbl[8]  = mk(8'hff, 1, 70, 50, 2, 0, 70,  50, 1, 1, 8'hff, 8, 0);
        tbl[9]  = mk(8'hff, 1, 63,  0, 1, 3, 255,  0, 0, 0, 8'hf7, 7, 0);
        tbl[10] = mk(8'hff, 1, 65, 20, 1, 5, 65,  20, 1, 0, 8'hf7, 7, 0);
        tbl[11] = mk(8'hff, 0, 99, 10, 0, 0, 0,    0, 0, 0, 8'hf7, 7, 1);
        tbl[12] = mk(8'hff, 1, 80, 90, 1, 3, 80,  90, 1, 0, 8'hff, 8, 1);
        tbl[13] = mk(8'hff, 0, 62, 33, 1, 2, 255, 33, 0, 0, 8'hfb, 7, 1);
        tbl[14] = mk(8'hfb, 1, 90, 70, 1, 2, 90,  70, 1, 0, 8'hff, 8, 1);

        repeat (3) @(posedge CLOCK_25);
        #1 iRST_N = 1'b1;
        @(negedge CLOCK_25);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_keys_on", int'(keys_on), 0);
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_evt_voice", int'(evt_voice), 0);
        chk("rst_evt_key", int'(evt_key), 255);
        chk("rst_evt_vel", int'(evt_vel), 0);
        chk("rst_evt_on", int'(evt_on), 0);
        chk("rst_evt_steal", int'(evt_steal), 0);
        chk("rst_active_count", int'(active_count), 0);
        chk("rst_off_miss", int'(off_miss), 0);

        foreach (tbl[i]) run_rec(tbl[i]);

        // all_off while a note on is scanning: dropped, gates cleared, ready next cycle
        start_req(1'b1, 50, 10);
        repeat (3) @(posedge CLOCK_25);
        #1 all_off = 1'b1;
        @(posedge CLOCK_25); #1 all_off = 1'b0;
        chk("alloff_req_ready", int'(req_ready), 1);
        chk("alloff_keys_on", int'(keys_on), 0);
        chk("alloff_active_count", int'(active_count), 0);
        count_quiet("alloff_scan_events", 14);
        chk("alloff_off_miss_kept", int'(off_miss), 1);

        // all_off coincident with note_req: request must not be accepted
        @(negedge CLOCK_25);
        note_req = 1'b1; note_on_off = 1'b1; note_key = 7'd55; note_vel = 7'd40; all_off = 1'b1;
        @(posedge CLOCK_25); #1;
        note_req = 1'b0; all_off = 1'b0;
        chk("alloff_wins_ready", int'(req_ready), 1);
        count_quiet("alloff_wins_events", 12);

        // reset in the middle of a scan aborts with no event
        start_req(1'b1, 40, 10);
        repeat (4) @(posedge CLOCK_25);
        #1 iRST_N = 1'b0;
        @(posedge CLOCK_25); #1 iRST_N = 1'b1;
        count_quiet("rst_scan_events", 14);
        chk("rst_scan_keys_on", int'(keys_on), 0);
        chk("rst_scan_off_miss", int'(off_miss), 0);
        chk("rst_scan_ready", int'(req_ready), 1);

        // note on then the same key with velocity 0 releases voice 0
        run_rec(mk(8'hff, 1, 60, 100, 1, 0, 60, 100, 1, 0, 8'h01, 1, 0));
        run_rec(mk(8'hff, 1, 60,   0, 1, 0, 255,  0, 0, 0, 8'h00, 0, 0));

        repeat (3) @(posedge CLOCK_25);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
